// File: rtl/mem_byte_requester.sv
// Splits CPU byte/halfword/word accesses into sequential little-endian byte
// requests on the byte-wide memory port; assembles and extends load data.
module mem_byte_requester #(
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  input  logic [31:0]           i_addr,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata,
  output logic                  o_done,
  output logic                  o_busy,
  output logic                  o_mem_request,
  output logic                  o_mem_write,
  output logic [ADDR_WIDTH-1:0] o_mem_address,
  output logic [7:0]            o_mem_data,
  input  logic [7:0]            i_mem_data,
  input  logic                  i_mem_data_DV
);

  // state | meaning
  // IDLE  | no access in progress, accepting i_req
  // ISSUE | request for byte k is on the memory port
  // WAIT  | waiting for the memory response to byte k
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  we_q, uns_q;
  logic [1:0]            size_q;
  logic [1:0]            k_q, k_d, last_k;
  logic [ADDR_WIDTH-1:0] addr_q, mem_addr_d;
  logic [31:0]           wdata_q;
  logic [31:0]           asm_q, asm_d;
  logic [31:0]           rdata_d;
  logic                  mem_req_d, mem_write_d, done_d, accept;
  logic [7:0]            mem_data_d;
  logic                  unused_addr_hi;

  assign unused_addr_hi = ^i_addr[31:ADDR_WIDTH];
  assign o_busy         = (state_q != IDLE);
  assign last_k         = (size_q == 2'b00) ? 2'd0 : (size_q == 2'b01) ? 2'd1 : 2'd3;

  // Memory-port outputs are registered, so they are computed here for the
  // state being entered: a request shows up in the first cycle of ISSUE.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    asm_d       = asm_q;
    mem_req_d   = 1'b0;
    mem_write_d = o_mem_write;
    mem_addr_d  = o_mem_address;
    mem_data_d  = o_mem_data;
    done_d      = 1'b0;
    accept      = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req) begin
          accept      = 1'b1;
          state_d     = ISSUE;
          k_d         = 2'd0;
          asm_d       = '0;
          mem_req_d   = 1'b1;
          mem_write_d = i_we;
          mem_addr_d  = i_addr[ADDR_WIDTH-1:0];
          mem_data_d  = i_wdata[7:0];
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (i_mem_data_DV) begin
          if (!we_q) asm_d[{k_q, 3'b000} +: 8] = i_mem_data;
          if (k_q != last_k) begin
            k_d        = k_q + 2'd1;
            state_d    = ISSUE;
            mem_req_d  = 1'b1;
            mem_addr_d = addr_q + ADDR_WIDTH'(k_d);
            mem_data_d = wdata_q[{k_d, 3'b000} +: 8];
          end else begin
            k_d     = 2'd0;
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (size_q)
      2'b00:   rdata_d = {{24{~uns_q & asm_d[7]}}, asm_d[7:0]};
      2'b01:   rdata_d = {{16{~uns_q & asm_d[15]}}, asm_d[15:0]};
      default: rdata_d = asm_d;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= IDLE;
      k_q           <= 2'd0;
      asm_q         <= '0;
      we_q          <= 1'b0;
      uns_q         <= 1'b0;
      size_q        <= 2'b00;
      addr_q        <= '0;
      wdata_q       <= '0;
      o_mem_request <= 1'b0;
      o_mem_write   <= 1'b0;
      o_mem_address <= '0;
      o_mem_data    <= '0;
      o_done        <= 1'b0;
      o_rdata       <= '0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      asm_q         <= asm_d;
      o_mem_request <= mem_req_d;
      o_mem_write   <= mem_write_d;
      o_mem_address <= mem_addr_d;
      o_mem_data    <= mem_data_d;
      o_done        <= done_d;
      if (accept) begin
        we_q    <= i_we;
        size_q  <= i_size;
        uns_q   <= i_unsigned;
        addr_q  <= i_addr[ADDR_WIDTH-1:0];
        wdata_q <= i_wdata;
      end
      if (done_d && !we_q) o_rdata <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_byte_requester.sv
// Bench for mem_byte_requester: byte-array memory responder plus a reference
// model that predicts load values, addresses and latency from access rules.
module tb_mem_byte_requester;
  localparam int AW  = 13;
  localparam int MSZ = 1 << AW;

  logic          i_clk = 1'b0, i_rst_n = 1'b1;
  logic          i_req = 1'b0, i_we = 1'b0, i_unsigned = 1'b0;
  logic [1:0]    i_size = 2'b00;
  logic [31:0]   i_addr = '0, i_wdata = '0;
  logic [31:0]   o_rdata;
  logic          o_done, o_busy, o_mem_request, o_mem_write;
  logic [AW-1:0] o_mem_address;
  logic [7:0]    o_mem_data;
  logic [7:0]    i_mem_data = '0;
  logic          i_mem_data_DV = 1'b0;

  mem_byte_requester #(.ADDR_WIDTH(AW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_we(i_we), .i_size(i_size),
    .i_unsigned(i_unsigned), .i_addr(i_addr), .i_wdata(i_wdata), .o_rdata(o_rdata),
    .o_done(o_done), .o_busy(o_busy), .o_mem_request(o_mem_request),
    .o_mem_write(o_mem_write), .o_mem_address(o_mem_address), .o_mem_data(o_mem_data),
    .i_mem_data(i_mem_data), .i_mem_data_DV(i_mem_data_DV)
  );

  always #5 i_clk = ~i_clk;

  int total = 0, bad = 0;
  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  logic [7:0]    mem     [MSZ];
  logic [7:0]    ref_mem [MSZ];
  logic [AW-1:0] addr_log[$];
  logic [7:0]    data_log[$];
  int            req_idx = 0, dly_byte = -1, dly_amt = 0, done_cnt = 0;
  bit            spur = 1'b0, pend = 1'b0;
  int            pend_dly = 0;
  logic [AW-1:0] pend_addr = '0;
  logic [31:0]   last_rd = '0;

  // Memory responder: DV the cycle after each request, optionally delayed.
  always @(negedge i_clk) begin
    i_mem_data_DV = 1'b0;
    if (!i_rst_n) pend = 1'b0;
    else if (pend) begin
      if (pend_dly == 0) begin
        i_mem_data_DV = 1'b1;
        i_mem_data    = mem[pend_addr];
        pend          = 1'b0;
      end else pend_dly--;
    end
    if (spur) begin
      i_mem_data_DV = 1'b1;
      i_mem_data    = 8'hEE;
    end
    if (o_mem_request) begin
      pend      = 1'b1;
      pend_addr = o_mem_address;
      pend_dly  = (req_idx == dly_byte) ? dly_amt : 0;
      req_idx++;
      addr_log.push_back(o_mem_address);
      data_log.push_back(o_mem_data);
      if (o_mem_write) mem[o_mem_address] = o_mem_data;
    end
    if (o_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input int addr, input logic [1:0] size, input bit uns);
    longint v = 0;
    int n = nbytes(size);
    for (int i = 0; i < n; i++) v += longint'(ref_mem[(addr + i) % MSZ]) << (8 * i);
    if (n == 1 && !uns && v >= 128)   v += 64'hFFFF_FF00;
    if (n == 2 && !uns && v >= 32768) v += 64'hFFFF_0000;
    return v[31:0];
  endfunction

  // Waits for o_done; optionally pokes i_req in cycle 3 while busy.
  task automatic wait_done(input int acc, input bit poke, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge i_clk);
      i_req = poke && (cyc == acc + 3);
      if (i_req) begin
        i_we   = ~i_we;
        i_addr = i_addr ^ 32'h55;
      end
      if (cyc == acc + 1) chk("busy_c1", {31'b0, o_busy}, 32'd1);
      if (o_done) seen = 1'b1;
    end
    i_req = 1'b0;
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_access(input bit we, input logic [1:0] size, input bit uns, input int addr,
                           input logic [31:0] wdata, input int dbyte, input int damt, input bit poke);
    int n, acc, d0, exp_lat;
    bit seen;
    logic [31:0] exp_rd;
    n = nbytes(size);
    addr_log.delete();
    data_log.delete();
    req_idx  = 0;
    dly_byte = dbyte;
    dly_amt  = damt;
    exp_lat  = 1 + 2 * n + ((dbyte >= 0 && dbyte < n) ? damt : 0);
    exp_rd   = we ? last_rd : model_load(addr, size, uns);
    if (we) for (int i = 0; i < n; i++) ref_mem[(addr + i) % MSZ] = wdata[8 * i +: 8];
    d0 = done_cnt;
    @(negedge i_clk);
    i_req = 1'b1; i_we = we; i_size = size; i_unsigned = uns;
    i_addr = addr; i_wdata = wdata;
    acc = cyc;
    wait_done(acc, poke, seen);
    if (seen) begin
      chk("latency", cyc - acc, exp_lat);
      chk("busy_done", {31'b0, o_busy}, 32'd0);
      chk("rdata", o_rdata, exp_rd);
    end
    last_rd = exp_rd;
    repeat (2) @(negedge i_clk);
    chk("nreq", addr_log.size(), n);
    for (int i = 0; i < n && i < addr_log.size(); i++) begin
      chk("addr", {19'b0, addr_log[i]}, (addr + i) % MSZ);
      if (we) chk("wbyte", {24'b0, data_log[i]}, {24'b0, wdata[8 * i +: 8]});
    end
    chk("ndone", done_cnt - d0, 1);
  endtask

  initial begin
    int acc, d0;
    bit seen;
    for (int i = 0; i < MSZ; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    #1 i_rst_n = 1'b0;
    #1;
    chk("rst_rdata", o_rdata, 32'd0);
    chk("rst_ctl", {7'b0, o_busy, o_done, o_mem_request, o_mem_write, o_mem_data, o_mem_address}, 32'd0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;

    do_access(1, 2'b10, 0, 'h10, 32'hA1B2C3D4, -1, 0, 0);
    do_access(0, 2'b10, 0, 'h10, 32'h0, -1, 0, 0);
    chk("word_const", o_rdata, 32'hA1B2C3D4);

    mem['h20] = 8'h80; ref_mem['h20] = 8'h80;
    mem['h21] = 8'h7F; ref_mem['h21] = 8'h7F;
    do_access(0, 2'b00, 0, 'h20, 32'h0, -1, 0, 0);
    chk("sbyte_const", o_rdata, 32'hFFFFFF80);
    do_access(0, 2'b00, 1, 'h20, 32'h0, -1, 0, 0);
    chk("ubyte_const", o_rdata, 32'h00000080);
    do_access(0, 2'b01, 0, 'h20, 32'h0, -1, 0, 0);
    chk("shalf_const", o_rdata, 32'h00007F80);

    do_access(0, 2'b11, 0, 'h1FFE, 32'h0, -1, 0, 0);
    do_access(0, 2'b10, 0, 'h10, 32'h0, 1, 3, 0);
    do_access(0, 2'b10, 1, 'h40, 32'h0, -1, 0, 1);

    // DV while idle must not produce anything.
    d0 = done_cnt;
    addr_log.delete();
    @(negedge i_clk); spur = 1'b1;
    @(negedge i_clk); spur = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("spur_done", done_cnt - d0, 0);
    chk("spur_req", addr_log.size(), 0);
    chk("spur_busy", {31'b0, o_busy}, 32'd0);
    do_access(0, 2'b00, 1, 'h21, 32'h0, -1, 0, 0);

    // Back-to-back: i_req held through the first o_done cycle.
    addr_log.delete();
    req_idx = 0; dly_byte = -1;
    for (int i = 0; i < 4; i++) ref_mem['h100 + i] = 8'(32'h5AC3_E781 >> (8 * i));
    @(negedge i_clk);
    i_req = 1'b1; i_we = 1'b1; i_size = 2'b10; i_unsigned = 1'b0;
    i_addr = 'h100; i_wdata = 32'h5AC3_E781;
    acc = cyc;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge i_clk);
      if (o_done) seen = 1'b1;
    end
    chk("b2b_lat1", cyc - acc, 9);
    i_we = 1'b0; i_size = 2'b00; i_unsigned = 1'b1;
    acc = cyc;
    wait_done(acc, 1'b0, seen);
    chk("b2b_lat2", cyc - acc, 3);
    last_rd = model_load('h100, 2'b00, 1'b1);
    chk("b2b_rdata", o_rdata, last_rd);
    repeat (2) @(negedge i_clk);
    chk("b2b_nreq", addr_log.size(), 5);

    // Reset during byte 2 of a word store.
    addr_log.delete();
    req_idx = 0;
    d0 = done_cnt;
    @(negedge i_clk);
    i_req = 1'b1; i_we = 1'b1; i_size = 2'b10; i_addr = 'h300; i_wdata = 32'h1234_5678;
    acc = cyc;
    @(negedge i_clk);
    i_req = 1'b0;
    while (cyc < acc + 5) @(negedge i_clk);
    chk("pre_rst_req", {31'b0, o_mem_request}, 32'd1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("mid_rst_rdata", o_rdata, 32'd0);
    chk("mid_rst_ctl", {7'b0, o_busy, o_done, o_mem_request, o_mem_write, o_mem_data, o_mem_address}, 32'd0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    last_rd = '0;
    for (int i = 0; i < 3; i++) ref_mem['h300 + i] = 8'(32'h1234_5678 >> (8 * i));
    repeat (10) @(negedge i_clk);
    chk("rst_nodone", done_cnt - d0, 0);
    chk("rst_nreq", addr_log.size(), 3);
    chk("rst_idle", {31'b0, o_busy}, 32'd0);

    for (int t = 0; t < 40; t++) begin
      int a, db;
      a  = ($urandom % 4 == 0) ? (MSZ - 1 - int'($urandom % 3)) : int'($urandom % MSZ);
      db = ($urandom % 3 == 0) ? int'($urandom % 4) : -1;
      do_access(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, db,
                int'($urandom_range(1, 4)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_byte_requester.md
# mem_byte_requester

Initiator for the byte-wide, single-port on-chip memory (8-bit data, one request in flight, registered `DV` response). It sits between the CPU load/store path and that memory. It accepts one byte, halfword or word access at a time and splits it into sequential little-endian byte requests. For loads it assembles the returned bytes into a 32-bit result with sign or zero extension, then pulses `o_done`.

## Interface
- `ADDR_WIDTH`, default 13: memory byte-address width; memory holds 2^ADDR_WIDTH bytes.
- `i_clk`  in  1: single clock; all logic on the rising edge.
- `i_rst_n`  in  1: reset, asynchronous, active-low.
- `i_req`  in  1: CPU access strobe; sampled only while `o_busy`=0.
- `i_we`  in  1: 1 = store, 0 = load; sampled with `i_req`.
- `i_size`  in  2: 00 = byte, 01 = halfword, 10 or 11 = word.
- `i_unsigned`  in  1: load extension; 1 = zero-extend, 0 = sign-extend.
- `i_addr`  in  32: byte address; only bits [ADDR_WIDTH-1:0] are used.
- `i_wdata`  in  32: store data; byte k = bits [8k+7:8k].
- `o_rdata`  out  32: load result; valid in the `o_done` cycle and held until the next load completes.
- `o_done`  out  1: one-cycle completion pulse, for loads and stores.
- `o_busy`  out  1: access in progress.
- `o_mem_request`  out  1: memory request strobe, registered.
- `o_mem_write`  out  1: memory write qualifier, registered.
- `o_mem_address`  out  ADDR_WIDTH: memory byte address, registered.
- `o_mem_data`  out  8: memory write data, registered.
- `i_mem_data`  in  8: memory read data; valid while `i_mem_data_DV`=1.
- `i_mem_data_DV`  in  1: memory response valid; memory asserts it the cycle after every request, reads and writes alike.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- **IDLE**
  - On `i_req`=1, latch `i_we`, `i_size`, `i_unsigned`, `i_addr[ADDR_WIDTH-1:0]` and `i_wdata`.
  - Set byte count n (1, 2 or 4) and clear byte index k to 0.
  - Go to ISSUE.
- **ISSUE**
  - Drive `o_mem_request`=1 for exactly one cycle.
  - `o_mem_address` = latched address + k, modulo 2^ADDR_WIDTH (wraps from 2^ADDR_WIDTH−1 to 0).
  - `o_mem_write` = latched `we`; `o_mem_data` = latched wdata byte k.
  - Go to WAIT.
- **WAIT**
  - Hold `o_mem_request`=0.
  - On `i_mem_data_DV`=1 and load: capture `i_mem_data` into assembly byte k.
  - On `i_mem_data_DV`=1: if k < n−1, increment k and go to ISSUE; otherwise go to IDLE and pulse `o_done` next cycle.
  - With no DV, stay in WAIT indefinitely. There is no timeout.
- **Load result at completion**
  - `o_rdata` = assembled bytes, extended from bit 7 (byte) or bit 15 (halfword), using zero or sign extension per `i_unsigned`.
  - Word loads take all 32 bits unchanged.
- Stores leave `o_rdata` unchanged.
- Unaligned addresses are legal; each byte is an independent request.
- `i_req` while `o_busy`=1 is ignored and not queued.
- `i_mem_data_DV` in IDLE or ISSUE is ignored.

## Timing
- Reset values: all outputs 0, FSM in IDLE, k = 0, `o_rdata` = 0.
- Assertion of `i_rst_n` mid-access:
  - All outputs drop to 0 immediately.
  - No further memory requests are issued.
  - No `o_done` is generated.
- Cycle numbering: acceptance is cycle 0 (IDLE, `i_req`=1).
  - Byte k request appears in cycle 1+2k.
  - Its DV is expected in cycle 2+2k.
  - `o_done` appears in cycle 1+2n.
- Latency from acceptance to `o_done`: byte 3 cycles, halfword 5 cycles, word 9 cycles.
- `o_busy` is 1 from cycle 1 through cycle 2n, and 0 in the `o_done` cycle.
- A new `i_req` in the `o_done` cycle is accepted, allowing back-to-back accesses with no bubble.
- A late DV stretches WAIT. Each extra cycle of DV delay adds one cycle to the latency.

## Test plan
- **Word store then word load.** Store `i_addr`=0x10, `i_wdata`=0xA1B2C3D4. Then load from 0x10.
  - Store: requests at 0x10..0x13 with data D4, C3, B2, A1; `o_done` in cycle 9.
  - Load: `o_rdata`=0xA1B2C3D4 with `o_done` in cycle 9.
- **Byte and halfword extension.** Memory holds 0x80 at 0x20 and 0x7F at 0x21.
  - Signed byte load at 0x20 → 0xFFFFFF80.
  - Unsigned byte load at 0x20 → 0x00000080.
  - Signed halfword load at 0x20 → 0x00007F80.
- **Address wrap-around.** Word load at 0x1FFE with ADDR_WIDTH=13 → addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001 in that order.
- **Back-to-back and ignored requests.**
  - Hold `i_req`=1 continuously: a second access is accepted in the first `o_done` cycle.
  - Pulse `i_req` while `o_busy`=1: no extra memory requests, no extra `o_done`.
- **Delayed and spurious DV.**
  - Delay DV by 3 cycles on byte 1 of a word load → `o_done` in cycle 12 with correct data.
  - Assert DV in IDLE → no effect.
- **Reset mid-access.** Assert `i_rst_n`=0 during byte 2 of a word store → all outputs 0 at once; after release the FSM is in IDLE and no `o_done` is ever produced for the aborted access.
